// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_pkg
//  Purpose  : Shared constants for the hazard scoreboard: forwarding mux
//             encodings, minimum multi-cycle latency and unit indices.
//  Revision : 1.0  initial release
// ============================================================================
package hazard_pkg;

  // Forwarding mux select codes for the Execute-stage operand muxes
  localparam logic [1:0] FWD_RF = 2'b00;  // register file value
  localparam logic [1:0] FWD_W  = 2'b01;  // ResultW
  localparam logic [1:0] FWD_M  = 2'b10;  // ALUResultM

  // Shortest multi-cycle latency; anything shorter could overtake older
  // single-cycle writes still travelling through Memory/Writeback.
  localparam int MIN_MC_LAT = 3;

  // Multi-cycle unit indices
  localparam int UNIT_FPU    = 0;
  localparam int UNIT_CRYPTO = 1;

  // Forward select from the two stage hits; Memory is younger so it wins.
  function automatic logic [1:0] fwd_code(input logic hit_m, input logic hit_w);
    if (hit_m)      return FWD_M;
    else if (hit_w) return FWD_W;
    else            return FWD_RF;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_unit_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : mc_unit_tracker
//  Purpose  : Occupancy tracker for one multi-cycle unit. Holds busy flag,
//             remaining-cycle counter and destination register, and raises
//             a completion request until the arbiter grants it.
//  Ports    : clk, rst (sync, active-low)
//             issue_i/lat_i/rd_i : accepted issue, latency, destination
//             grant_i            : write-back granted this cycle
//             busy_o/req_o/rd_o  : occupied, completing, destination
//  Revision : 1.0  initial release
// ============================================================================
module mc_unit_tracker
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 3,
  parameter int LAT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_i,
  input  logic [LAT_W-1:0]      lat_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  grant_i,
  output logic                  busy_o,
  output logic                  req_o,
  output logic [REG_ADDR_W-1:0] rd_o
);

  logic                  busy_q, busy_d;
  logic [LAT_W-1:0]      cnt_q, cnt_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [LAT_W-1:0]      lat_eff;

  assign lat_eff = (lat_i < LAT_W'(MIN_MC_LAT)) ? LAT_W'(MIN_MC_LAT) : lat_i;

  // The issue cycle itself is the first latency cycle, so the counter is
  // loaded with latency-1 and reaches 1 in the completion cycle N+L-1.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rd_d   = rd_q;
    if (busy_q) begin
      if (cnt_q == LAT_W'(1)) begin
        if (grant_i) busy_d = 1'b0;   // losing units hold at 1
      end else begin
        cnt_d = cnt_q - LAT_W'(1);
      end
    end else if (issue_i) begin
      busy_d = 1'b1;
      cnt_d  = lat_eff - LAT_W'(1);
      rd_d   = rd_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rd_q   <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
    end
  end

  assign busy_o = busy_q;
  assign req_o  = busy_q & (cnt_q == LAT_W'(1));
  assign rd_o   = rd_q;

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scoreboard
//  Purpose  : Pipeline hazard unit with forwarding, load-use stall, branch
//             flush and a register scoreboard for variable-latency units.
//  Ports    : Decode/Execute/Memory/Writeback register info in;
//             Forward_A_E/Forward_B_E, StallF/StallD/FlushD/FlushE out;
//             mc_busy and mc_wb_valid/mc_wb_rd/mc_wb_unit (registered) out.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 3,
  parameter int NUM_MC     = 2,
  parameter int LAT_W      = 4,
  parameter int UNIT_W     = (NUM_MC > 1) ? $clog2(NUM_MC) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] RdD,
  input  logic                  RegwriteD,
  input  logic                  mc_req_D,
  input  logic [UNIT_W-1:0]     mc_unit_D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic                  RegwriteE,
  input  logic                  ResultSrcE0,
  input  logic                  PCSrcE,
  input  logic                  mc_issue_E,
  input  logic [UNIT_W-1:0]     mc_unit_E,
  input  logic [LAT_W-1:0]      mc_lat_E,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegwriteM,
  input  logic                  RegwriteW,
  output logic [1:0]            Forward_A_E,
  output logic [1:0]            Forward_B_E,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [NUM_MC-1:0]     mc_busy,
  output logic                  mc_wb_valid,
  output logic [REG_ADDR_W-1:0] mc_wb_rd,
  output logic [UNIT_W-1:0]     mc_wb_unit
);

  localparam int NUM_REGS = 1 << REG_ADDR_W;

  logic [NUM_REGS-1:0]   pending_q, pending_d;
  logic                  wb_valid_q;
  logic [REG_ADDR_W-1:0] wb_rd_q;
  logic [UNIT_W-1:0]     wb_unit_q;

  logic [NUM_MC-1:0]     busy, req, grant, accept;
  logic [REG_ADDR_W-1:0] unit_rd [NUM_MC];
  logic                  gnt_any;
  logic [UNIT_W-1:0]     gnt_idx;
  logic [REG_ADDR_W-1:0] gnt_rd;

  // RegwriteE is not needed: Execute results are covered by forwarding.
  logic unused_ok;
  assign unused_ok = RegwriteE;

  generate
    for (genvar u = 0; u < NUM_MC; u++) begin : g_unit
      // An issue to a unit that is still busy is dropped.
      assign accept[u] = mc_issue_E & (mc_unit_E == UNIT_W'(u)) & ~busy[u];

      mc_unit_tracker #(
        .REG_ADDR_W(REG_ADDR_W),
        .LAT_W     (LAT_W)
      ) u_trk (
        .clk    (clk),
        .rst    (rst),
        .issue_i(accept[u]),
        .lat_i  (mc_lat_E),
        .rd_i   (RdE),
        .grant_i(grant[u]),
        .busy_o (busy[u]),
        .req_o  (req[u]),
        .rd_o   (unit_rd[u])
      );
    end
  endgenerate

  // Fixed-priority completion arbiter: lowest unit index wins.
  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt_rd  = '0;
    for (int u = 0; u < NUM_MC; u++) begin
      if (req[u] && !gnt_any) begin
        grant[u] = 1'b1;
        gnt_any  = 1'b1;
        gnt_idx  = UNIT_W'(u);
        gnt_rd   = unit_rd[u];
      end
    end
  end

  // Retire before set so an issue landing on the same edge wins.
  always_comb begin
    pending_d = pending_q;
    if (gnt_any) pending_d[gnt_rd] = 1'b0;
    if ((|accept) && (RdE != '0)) pending_d[RdE] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_unit_q  <= '0;
    end else begin
      pending_q  <= pending_d;
      wb_valid_q <= gnt_any;
      if (gnt_any) begin
        wb_rd_q   <= gnt_rd;
        wb_unit_q <= gnt_idx;
      end
    end
  end

  // Combinational hazard detection
  logic unit_d_busy, lu_stall, sb_stall, stall;
  logic [1:0] fwd_a, fwd_b;

  always_comb begin
    unit_d_busy = 1'b0;
    for (int u = 0; u < NUM_MC; u++) begin
      if (mc_unit_D == UNIT_W'(u)) unit_d_busy = busy[u];
    end
  end

  assign fwd_a = fwd_code(RegwriteM && RdM != '0 && RdM == Rs1E,
                          RegwriteW && RdW != '0 && RdW == Rs1E);
  assign fwd_b = fwd_code(RegwriteM && RdM != '0 && RdM == Rs2E,
                          RegwriteW && RdW != '0 && RdW == Rs2E);

  assign lu_stall = ResultSrcE0 && (RdE != '0) && (RdE == Rs1D || RdE == Rs2D);

  // Issue shadow covers the cycle before the scoreboard bit is visible.
  assign sb_stall = (mc_issue_E && (RdE != '0) &&
                      (RdE == Rs1D || RdE == Rs2D || (RegwriteD && RdE == RdD)))
                  || pending_q[Rs1D] || pending_q[Rs2D]
                  || (RegwriteD && pending_q[RdD])
                  || (mc_req_D && (unit_d_busy || (mc_issue_E && mc_unit_E == mc_unit_D)));

  assign stall = lu_stall | sb_stall;

  assign Forward_A_E = rst ? fwd_a : FWD_RF;
  assign Forward_B_E = rst ? fwd_b : FWD_RF;
  assign StallF      = rst & stall;
  assign StallD      = rst & stall;
  assign FlushE      = rst & (stall | PCSrcE);
  assign FlushD      = rst & PCSrcE;

  assign mc_busy     = busy;
  assign mc_wb_valid = wb_valid_q;
  assign mc_wb_rd    = wb_rd_q;
  assign mc_wb_unit  = wb_unit_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_scoreboard
//  Purpose  : Self-checking bench for hazard_scoreboard: directed scenarios
//             followed by random legal traffic against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_scoreboard;

  localparam int RW = 3;
  localparam int NM = 2;
  localparam int LW = 4;
  localparam int UW = 1;

  logic clk;
  logic rst;
  logic [RW-1:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegwriteD, mc_req_D, RegwriteE, ResultSrcE0, PCSrcE, mc_issue_E;
  logic RegwriteM, RegwriteW;
  logic [UW-1:0] mc_unit_D, mc_unit_E;
  logic [LW-1:0] mc_lat_E;
  logic [1:0] Forward_A_E, Forward_B_E;
  logic StallF, StallD, FlushD, FlushE;
  logic [NM-1:0] mc_busy;
  logic mc_wb_valid;
  logic [RW-1:0] mc_wb_rd;
  logic [UW-1:0] mc_wb_unit;

  hazard_scoreboard #(.REG_ADDR_W(RW), .NUM_MC(NM), .LAT_W(LW), .UNIT_W(UW)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegwriteD(RegwriteD),
    .mc_req_D(mc_req_D), .mc_unit_D(mc_unit_D),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegwriteE(RegwriteE),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .mc_issue_E(mc_issue_E), .mc_unit_E(mc_unit_E), .mc_lat_E(mc_lat_E),
    .RdM(RdM), .RdW(RdW), .RegwriteM(RegwriteM), .RegwriteW(RegwriteW),
    .Forward_A_E(Forward_A_E), .Forward_B_E(Forward_B_E),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .mc_busy(mc_busy), .mc_wb_valid(mc_wb_valid), .mc_wb_rd(mc_wb_rd),
    .mc_wb_unit(mc_wb_unit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model: each unit is either idle or owns a register until a known
  // completion cycle; write-backs are granted lowest index first.
  bit m_busy [NM];
  int m_done [NM];
  int m_rd   [NM];
  bit m_wv;
  int m_wrd, m_wu;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit pend(input int r);
    if (r == 0) return 1'b0;
    for (int u = 0; u < NM; u++) if (m_busy[u] && m_rd[u] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int fwd(input int rs);
    if (RegwriteM && RdM != 0 && int'(RdM) == rs) return 2;
    if (RegwriteW && RdW != 0 && int'(RdW) == rs) return 1;
    return 0;
  endfunction

  task automatic check_all();
    bit lu, sb, st;
    int ea, eb;
    logic [NM-1:0] eb_vec;
    lu = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    sb = (mc_issue_E && RdE != 0 && (RdE == Rs1D || RdE == Rs2D || (RegwriteD && RdE == RdD)))
       || pend(int'(Rs1D)) || pend(int'(Rs2D)) || (RegwriteD && pend(int'(RdD)))
       || (mc_req_D && (m_busy[mc_unit_D] || (mc_issue_E && mc_unit_E == mc_unit_D)));
    st = rst && (lu || sb);
    ea = rst ? fwd(int'(Rs1E)) : 0;
    eb = rst ? fwd(int'(Rs2E)) : 0;
    for (int u = 0; u < NM; u++) eb_vec[u] = m_busy[u];
    chk("fwdA", 32'(Forward_A_E), 32'(ea));
    chk("fwdB", 32'(Forward_B_E), 32'(eb));
    chk("StallF", 32'(StallF), 32'(st));
    chk("StallD", 32'(StallD), 32'(st));
    chk("FlushE", 32'(FlushE), 32'(st || (rst && PCSrcE)));
    chk("FlushD", 32'(FlushD), 32'(rst && PCSrcE));
    chk("mc_busy", 32'(mc_busy), 32'(eb_vec));
    chk("wb_valid", 32'(mc_wb_valid), 32'(m_wv));
    if (m_wv) begin
      chk("wb_rd", 32'(mc_wb_rd), 32'(m_wrd));
      chk("wb_unit", 32'(mc_wb_unit), 32'(m_wu));
    end
  endtask

  task automatic model_edge();
    bit pre [NM];
    int w;
    int lat;
    if (!rst) begin
      for (int u = 0; u < NM; u++) m_busy[u] = 1'b0;
      m_wv = 1'b0;
    end else begin
      for (int u = 0; u < NM; u++) pre[u] = m_busy[u];
      w = -1;
      for (int u = 0; u < NM; u++) if (w < 0 && m_busy[u] && cyc >= m_done[u]) w = u;
      if (w >= 0) begin
        m_wv = 1'b1; m_wrd = m_rd[w]; m_wu = w; m_busy[w] = 1'b0;
      end else begin
        m_wv = 1'b0;
      end
      if (mc_issue_E && !pre[mc_unit_E]) begin
        lat = (int'(mc_lat_E) < 3) ? 3 : int'(mc_lat_E);
        m_busy[mc_unit_E] = 1'b1;
        m_done[mc_unit_E] = cyc + lat - 1;
        m_rd[mc_unit_E]   = int'(RdE);
      end
    end
  endtask

  // Settle, check, clock edge, advance model; inputs change at edge+1.
  task automatic settle();
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic step();
    settle(); check_all(); tick();
  endtask

  task automatic idle_inputs();
    {Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegwriteD, mc_req_D, RegwriteE, ResultSrcE0, PCSrcE, mc_issue_E} = '0;
    {RegwriteM, RegwriteW} = '0;
    mc_unit_D = '0; mc_unit_E = '0; mc_lat_E = '0;
  endtask

  task automatic issue(input int unit, input int lat, input int rd);
    mc_issue_E = 1'b1; mc_unit_E = UW'(unit); mc_lat_E = LW'(lat); RdE = RW'(rd);
  endtask

  task automatic rand_inputs();
    Rs1D = RW'($urandom); Rs2D = RW'($urandom); RdD = RW'($urandom);
    Rs1E = RW'($urandom); Rs2E = RW'($urandom); RdE = RW'($urandom);
    RdM = RW'($urandom); RdW = RW'($urandom);
    RegwriteD = 1'($urandom); mc_req_D = 1'($urandom); mc_unit_D = UW'($urandom);
    RegwriteE = 1'($urandom); ResultSrcE0 = ($urandom_range(0, 3) == 0);
    PCSrcE = ($urandom_range(0, 4) == 0);
    RegwriteM = 1'($urandom); RegwriteW = 1'($urandom);
    mc_unit_E = UW'($urandom); mc_lat_E = LW'($urandom);
    // Only legal issues: free unit and destination not already owned.
    mc_issue_E = ($urandom_range(0, 2) == 0) && !m_busy[mc_unit_E] && !pend(int'(RdE));
    rst = ($urandom_range(0, 59) != 0);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    @(posedge clk); #1;
    // Reset state
    step();
    settle();
    chk("reset_busy", 32'(mc_busy), 32'd0);
    chk("reset_wb", 32'(mc_wb_valid), 32'd0);
    check_all(); tick();
    rst = 1'b1;

    // Forwarding: M beats W, W alone, register 0
    RegwriteM = 1; RdM = 3; Rs1E = 3; RegwriteW = 1; RdW = 5; Rs2E = 5;
    settle(); chk("fwdA_M", 32'(Forward_A_E), 32'd2); chk("fwdB_W", 32'(Forward_B_E), 32'd1);
    check_all(); tick();
    RdW = 3;
    step();
    RdM = 0; RdW = 0; Rs1E = 0;
    settle(); chk("fwdA_r0", 32'(Forward_A_E), 32'd0); check_all(); tick();
    idle_inputs();

    // Load-use
    ResultSrcE0 = 1; RdE = 2; Rs2D = 2;
    settle(); chk("lu_stall", 32'(StallD), 32'd1); chk("lu_flushD", 32'(FlushD), 32'd0);
    check_all(); tick();
    idle_inputs();
    step();

    // FPU lat 5, rd 4, Decode reading r4 throughout
    issue(0, 5, 4); Rs1D = 4;
    step();
    mc_issue_E = 0; RdE = 0;
    for (int k = 1; k <= 5; k++) begin
      settle();
      if (k < 5) chk("fpu_stall", 32'(StallD), 32'd1);
      else begin
        chk("fpu_release", 32'(StallD), 32'd0);
        chk("fpu_wb", 32'(mc_wb_valid), 32'd1);
        chk("fpu_wb_rd", 32'(mc_wb_rd), 32'd4);
      end
      check_all(); tick();
    end
    idle_inputs();

    // Latency 1 clamps to 3
    issue(1, 1, 6);
    step();
    idle_inputs();
    for (int k = 1; k <= 3; k++) begin
      settle();
      chk("lat1_wb", 32'(mc_wb_valid), 32'(k == 3));
      check_all(); tick();
    end

    // Simultaneous completion
    issue(0, 6, 1); step();
    issue(1, 5, 2); step();
    idle_inputs(); Rs1D = 2;
    for (int k = 0; k < 7; k++) step();
    idle_inputs();

    // Reset while both units busy
    issue(0, 15, 3); step();
    issue(1, 15, 5); step();
    idle_inputs(); step();
    rst = 0; step();
    rst = 1; Rs1D = 3; Rs2D = 5;
    settle();
    chk("rst_mid_busy", 32'(mc_busy), 32'd0);
    chk("rst_mid_stall", 32'(StallD), 32'd0);
    check_all(); tick();
    idle_inputs();

    // Random legal traffic
    for (int n = 0; n < 600; n++) begin
      rand_inputs();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
